// File: rtl/aes_core_arbiter_pkg.sv
// Shared definitions for the AES core arbiter.
//   DATA_W / RND_W : operand and round-count widths
//   NUM_REQ        : number of requesters sharing the core
//   req_idx_t      : requester index
//   state_e        : sequencer states
package aes_pkg;
  localparam int DATA_W  = 16;
  localparam int RND_W   = 4;
  localparam int NUM_REQ = 2;

  typedef logic [$clog2(NUM_REQ)-1:0] req_idx_t;

  typedef enum logic [1:0] {IDLE, LOAD, BUSY, RESP} state_e;
endpackage

// File: rtl/aes_core_arbiter_if.sv
// Requester-side bus of the AES core arbiter.
//   req_valid/req_ready          : per-requester job handshake
//   req_data/key/iv/rounds       : per-requester job operands, [i] = requester i
//   rsp_valid/rsp_ready          : per-requester result handshake
//   rsp_data/rsp_err             : shared result bus, qualified by rsp_valid
// master = requesters, slave = arbiter.
interface aes_core_arbiter_if
  import aes_pkg::*;
#(
  parameter int DATA_W = aes_pkg::DATA_W,
  parameter int RND_W  = aes_pkg::RND_W
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_key;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_iv;
  logic [NUM_REQ-1:0][RND_W-1:0]  req_rounds;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [NUM_REQ-1:0]             rsp_ready;
  logic [DATA_W-1:0]              rsp_data;
  logic                           rsp_err;

  modport master (
    output req_valid, req_data, req_key, req_iv, req_rounds, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_data, req_key, req_iv, req_rounds, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/aes_core_arbiter_rr_picker.sv
// Two-input round-robin grant, purely combinational.
//   valid_i       : per-requester valid
//   rr_ptr_i      : preferred requester
//   grant_valid_o : some requester is valid
//   grant_idx_o   : winner; the preferred one unless it is idle
module aes_rr_picker
  import aes_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid_i,
  input  req_idx_t           rr_ptr_i,
  output logic               grant_valid_o,
  output req_idx_t           grant_idx_o
);
  assign grant_valid_o = |valid_i;
  assign grant_idx_o   = valid_i[rr_ptr_i] ? rr_ptr_i : ~rr_ptr_i;
endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one AES core between two requesters. Grants round-robin, registers
// the winner's operands, pulses core_load, waits for a rising core_finish and
// returns the result to the owner. One job in flight at a time.
//   clk, nrst          : clock, async active-low reset
//   bus (slave)        : requester job/result handshakes
//   core_load          : one-cycle start pulse to the core
//   core_data_input / core_input_vector / core_key / core_round_number
//                      : registered operands, held between jobs
//   core_data_output   : core ciphertext
//   core_finish        : core done level
// Build option: AES_ARB_TIMEOUT_EN adds a BUSY watchdog of TIMEOUT_CYC cycles
// that returns an error response when the core never finishes.
module aes_core_arbiter
  import aes_pkg::*;
#(
  parameter int DATA_W      = aes_pkg::DATA_W,
  parameter int RND_W       = aes_pkg::RND_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              nrst,
  aes_core_arbiter_if.slave bus,
  output logic              core_load,
  output logic [DATA_W-1:0] core_data_input,
  output logic [DATA_W-1:0] core_input_vector,
  output logic [DATA_W-1:0] core_key,
  output logic [RND_W-1:0]  core_round_number,
  input  logic [DATA_W-1:0] core_data_output,
  input  logic              core_finish
);
  state_e            state_q, state_d;
  req_idx_t          owner_q, rr_ptr_q, gnt_idx;
  logic              gnt_vld, accept, rsp_hs, fin_q, fin_edge, to_hit, zero_rnd;
  logic [DATA_W-1:0] din_q, iv_q, key_q, res_q;
  logic [RND_W-1:0]  rnd_q;
  logic              err_q;

  aes_rr_picker u_pick (
    .valid_i       (bus.req_valid),
    .rr_ptr_i      (rr_ptr_q),
    .grant_valid_o (gnt_vld),
    .grant_idx_o   (gnt_idx)
  );

  assign accept   = (state_q == IDLE) && gnt_vld;
  assign zero_rnd = (bus.req_rounds[gnt_idx] == '0);
  assign rsp_hs   = (state_q == RESP) && bus.rsp_ready[owner_q];
  // A finish level still high from the previous job carries no edge.
  assign fin_edge = core_finish && !fin_q;

`ifdef AES_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0] to_cnt_q;

  // Counts BUSY cycles; fires on the TIMEOUT_CYC-th one.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                 to_cnt_q <= '0;
    else if (state_q == BUSY)  to_cnt_q <= to_cnt_q + 1'b1;
    else                       to_cnt_q <= '0;
  end
  assign to_hit = (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  // No watchdog: BUSY waits for the core indefinitely. Constant-false, the
  // limit parameter stays on the port list so both builds share one interface.
  assign to_hit = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_vld) state_d = zero_rnd ? RESP : LOAD;
      LOAD:    state_d = BUSY;
      BUSY:    if (fin_edge || to_hit) state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    core_load     = 1'b0;
    case (state_q)
      // Gated by nrst so nothing looks accepted while reset holds the FSM.
      IDLE:    if (gnt_vld && nrst) bus.req_ready[gnt_idx] = 1'b1;
      LOAD:    core_load = 1'b1;
      RESP:    bus.rsp_valid[owner_q] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fin_q    <= 1'b0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      din_q    <= '0;
      iv_q     <= '0;
      key_q    <= '0;
      rnd_q    <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      fin_q <= core_finish;
      if (accept) begin
        owner_q <= gnt_idx;
        din_q   <= bus.req_data[gnt_idx];
        iv_q    <= bus.req_iv[gnt_idx];
        key_q   <= bus.req_key[gnt_idx];
        rnd_q   <= bus.req_rounds[gnt_idx];
        // Zero rounds skips the core and answers with an error directly.
        if (zero_rnd) begin
          res_q <= '0;
          err_q <= 1'b1;
        end
      end
      if (state_q == BUSY) begin
        if (fin_edge) begin
          res_q <= core_data_output;
          err_q <= 1'b0;
        end else if (to_hit) begin
          res_q <= '0;
          err_q <= 1'b1;
        end
      end
      if (rsp_hs) rr_ptr_q <= ~owner_q;
    end
  end

  assign bus.rsp_data      = res_q;
  assign bus.rsp_err       = err_q;
  assign core_data_input   = din_q;
  assign core_input_vector = iv_q;
  assign core_key          = key_q;
  assign core_round_number = rnd_q;
endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter with a core stub (finish 5 cycles after load,
// result = data ^ iv ^ key). Expected grant order follows the round-robin
// rule (preferred requester wins, preference flips to the other after each
// response); expected results come from the job operands the bench drove.
module tb_aes_core_arbiter;
  import aes_pkg::*;

  localparam int TO_CYC = 255;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        core_load, core_finish;
  logic [15:0] core_din, core_iv, core_key, core_dout;
  logic [3:0]  core_rnd;

  always #5 clk = ~clk;

  aes_core_arbiter_if bus ();

  aes_core_arbiter #(.TIMEOUT_CYC(TO_CYC)) dut (
    .clk               (clk),
    .nrst              (nrst),
    .bus               (bus),
    .core_load         (core_load),
    .core_data_input   (core_din),
    .core_input_vector (core_iv),
    .core_key          (core_key),
    .core_round_number (core_rnd),
    .core_data_output  (core_dout),
    .core_finish       (core_finish)
  );

  // Core stub
  int   stub_cnt;
  logic stub_fin;
  logic stub_hang = 1'b0;
  logic fin_force = 1'b0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stub_cnt <= 0;
      stub_fin <= 1'b0;
    end else if (core_load) begin
      stub_fin <= 1'b0;
      stub_cnt <= 5;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1 && !stub_hang) stub_fin <= 1'b1;
    end
  end
  assign core_finish = stub_fin | fin_force;
  assign core_dout   = core_din ^ core_iv ^ core_key;

  int ntests = 0;
  int nfail  = 0;
  int pref   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_req(input int i, input bit v, input bit zero_ok);
    bus.req_valid[i]  = v;
    bus.req_data[i]   = 16'($urandom);
    bus.req_key[i]    = 16'($urandom);
    bus.req_iv[i]     = 16'($urandom);
    bus.req_rounds[i] = (zero_ok && $urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
  endtask

  // Serves one job end to end: grant, load, result, optional backpressure.
  task automatic do_job(input bit refill, input int hold, input bit hang, output int g);
    logic [1:0]  oh;
    logic [15:0] d, ky, v, e_data;
    logic [3:0]  rnd;
    logic        e_err, pf;
    bit          got;
    int          n, fin_at, rsp_at, loads, bound;
    g = pref;
    stub_hang = hang;
    got = 0;
    n = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      got = (bus.req_ready != 2'b00);
    end
    check("grant_seen", got, 1);
    if (!got) return;
    g  = bus.req_valid[pref] ? pref : 1 - pref;
    oh = '0;
    oh[g] = 1'b1;
    check("grant_idx", bus.req_ready, oh);
    d = bus.req_data[g]; ky = bus.req_key[g]; v = bus.req_iv[g]; rnd = bus.req_rounds[g];
    if (rnd == 0 || hang) begin
      e_data = '0;
      e_err  = 1'b1;
    end else begin
      e_data = d ^ v ^ ky;
      e_err  = 1'b0;
    end
    @(posedge clk);
    #1;
    if (refill) rand_req(g, 1, 0);
    else bus.req_valid[g] = 1'b0;
    n = 0; loads = 0; fin_at = -1; rsp_at = -1; pf = 1'b1;
    bound = hang ? TO_CYC + 20 : 30;
    while (rsp_at < 0 && n < bound) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("load_lat", core_load, rnd != 4'd0);
        check("op_data", core_din, d);
        check("op_key", core_key, ky);
        check("op_iv", core_iv, v);
        check("op_rnd", core_rnd, rnd);
      end
      if (core_load) loads++;
      if (core_finish && !pf && fin_at < 0) fin_at = n;
      pf = core_finish;
      if (bus.rsp_valid != 2'b00) rsp_at = n;
    end
    check("rsp_seen", rsp_at >= 0, 1);
    if (rsp_at < 0) return;
    check("load_count", loads, rnd != 4'd0);
    check("rsp_valid", bus.rsp_valid, oh);
    check("rsp_data", bus.rsp_data, e_data);
    check("rsp_err", bus.rsp_err, e_err);
    if (rnd == 0)  check("zero_rnd_lat", rsp_at, 1);
    else if (hang) check("timeout_lat", rsp_at >= TO_CYC + 1 && rsp_at <= TO_CYC + 3, 1);
    else           check("fin_to_rsp", rsp_at - fin_at, 1);
    repeat (hold) begin
      @(negedge clk);
      check("bp_valid", bus.rsp_valid, oh);
      check("bp_data", bus.rsp_data, e_data);
      check("bp_ready", bus.req_ready, 2'b00);
      check("bp_load", core_load, 0);
    end
    bus.rsp_ready = oh;
    @(posedge clk);
    #1;
    bus.rsp_ready = '0;
    check("rsp_drop", bus.rsp_valid, 2'b00);
    pref = 1 - g;
    stub_hang = 1'b0;
  endtask

  initial begin
    int  g, n;
    bit  got;
    bus.req_valid = '0; bus.req_data = '0; bus.req_key = '0;
    bus.req_iv = '0; bus.req_rounds = '0; bus.rsp_ready = '0;

    // Reset state
    #12;
    check("rst_req_ready", bus.req_ready, 2'b00);
    check("rst_rsp_valid", bus.rsp_valid, 2'b00);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_load", core_load, 0);
    check("rst_ops", {core_din, core_key}, 0);
    @(posedge clk);
    #1 nrst = 1'b1;

    // Contention from reset: strict alternation 0,1,0,1,0,1
    rand_req(0, 1, 0);
    rand_req(1, 1, 0);
    for (int j = 0; j < 6; j++) begin
      do_job(1, 0, 0, g);
      check("alternate", g, j % 2);
    end
    bus.req_valid = '0;

    // Single directed job on requester 0
    bus.req_data[0] = 16'h6F6B; bus.req_key[0] = 16'hA73B;
    bus.req_iv[0] = 16'h0001; bus.req_rounds[0] = 4'd2;
    bus.req_valid[0] = 1'b1;
    do_job(0, 0, 0, g);
    check("single_owner", g, 0);

    // Backpressure on requester 1 while requester 0 waits
    rand_req(1, 1, 0);
    rand_req(0, 1, 0);
    do_job(0, 10, 0, g);
    check("bp_owner", g, 1);
    do_job(0, 0, 0, g);
    check("bp_next_owner", g, 0);

    // Async reset while BUSY; requester 1 stays valid through reset
    rand_req(0, 1, 0);
    got = 0;
    n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = bus.req_ready[0];
    end
    check("rst_grant", got, 1);
    @(posedge clk);
    #1 bus.req_valid[0] = 1'b0;
    rand_req(1, 1, 0);
    repeat (3) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    check("mid_rst_req_ready", bus.req_ready, 2'b00);
    check("mid_rst_rsp_valid", bus.rsp_valid, 2'b00);
    check("mid_rst_rsp_data", bus.rsp_data, 0);
    check("mid_rst_rsp_err", bus.rsp_err, 0);
    check("mid_rst_load", core_load, 0);
    check("mid_rst_din", core_din, 0);
    check("mid_rst_iv", core_iv, 0);
    check("mid_rst_key", core_key, 0);
    check("mid_rst_rnd", core_rnd, 0);
    @(posedge clk);
    #1 nrst = 1'b1;
    pref = 0;
    do_job(0, 0, 0, g);
    check("post_rst_owner", g, 1);

    // Zero rounds on requester 1
    rand_req(1, 1, 0);
    bus.req_rounds[1] = 4'd0;
    do_job(0, 0, 0, g);
    check("zero_owner", g, 1);

`ifdef AES_ARB_TIMEOUT_EN
    // Core never finishes; a late finish in IDLE must be ignored
    rand_req(0, 1, 0);
    do_job(0, 0, 1, g);
    fin_force = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("late_fin_valid", bus.rsp_valid, 2'b00);
      check("late_fin_load", core_load, 0);
    end
    fin_force = 1'b0;
    rand_req(1, 1, 0);
    do_job(0, 0, 0, g);
`endif

    // Randomized jobs
    for (int j = 0; j < 12; j++) begin
      rand_req(0, $urandom_range(0, 1) == 1, 1);
      rand_req(1, $urandom_range(0, 1) == 1, 1);
      if (bus.req_valid == 2'b00) bus.req_valid[$urandom_range(0, 1)] = 1'b1;
      do_job($urandom_range(0, 1) == 1, $urandom_range(0, 3), 0, g);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
